lut_equiv_checker: RTL and testbench
====================================

LUT_EQUIV_CHECKER -- requirements
Module: lut_equiv_checker

Interface
REQ-001 Parameter N, default 3, number of boolean inputs of the functions under check (legal 1..8).
REQ-002 Parameter T, default 2**N, truth-table width (derived; SHALL NOT be overridden).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request a new sweep; sampled on rising clk.
REQ-006 mode  input  2  check mode: 00 equal, 01 implication A->B, 10 complement A==~B, 11 treated as 00.
REQ-007 lut_a  input  T  truth table of function A; bit i = A(vec=i), vec MSB is first variable (x).
REQ-008 lut_b  input  T  truth table of function B, same encoding.
REQ-009 busy  output  1  high while sweeping.
REQ-010 done  output  1  one-cycle pulse, sweep complete.
REQ-011 equal  output  1  1 = no mismatch found under captured mode.
REQ-012 mismatch_count  output  N+1  number of mismatching vectors.
REQ-013 first_mismatch  output  N  lowest mismatching vector index.
REQ-014 first_valid  output  1  first_mismatch holds a valid index.
REQ-015 vec  output  N  vector currently evaluated (valid while busy).
REQ-016 fa, fb  output  1 each  A(vec), B(vec) from captured tables (valid while busy).

Function
REQ-017 FSM states IDLE, SWEEP, DONE; reset state IDLE.
REQ-018 IDLE with start=1 at an edge: capture lut_a, lut_b, mode; vec<=0; clear mismatch_count, first_mismatch, first_valid, equal; go SWEEP.
REQ-019 start outside IDLE SHALL be ignored (no capture, no restart); input table/mode changes after capture SHALL NOT affect the running sweep.
REQ-020 SWEEP, each edge: evaluate mismatch for vec; mode 00: fa!=fb; mode 01: fa&~fb; mode 10: fa==fb.
REQ-021 On mismatch: mismatch_count+=1; if first_valid=0, first_mismatch<=vec and first_valid<=1.
REQ-022 vec increments by 1 per cycle; at vec=T-1 the edge performs the final evaluation and goes DONE (no wrap to 0 inside a sweep).
REQ-023 DONE: done=1 for exactly one cycle; equal=(mismatch_count==0); next edge returns IDLE regardless of start.
REQ-024 Latency: start accepted at edge E -> busy high cycles E+1..E+T, done high cycle E+T+1; T evaluations per sweep, no gaps.
REQ-025 equal, mismatch_count, first_mismatch, first_valid SHALL hold from DONE until the next accepted start.
REQ-026 mismatch_count SHALL reach T without overflow (N+1 bits).
REQ-027 busy=1 only in SWEEP; done=1 only in DONE; busy and done never simultaneously high.
REQ-028 vec, fa, fb SHALL be 0 outside SWEEP.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE and all outputs to 0, independent of clk, including mid-sweep.
REQ-030 Captured tables/mode cleared to 0 on reset; first accepted start after release runs a full T-vector sweep.
REQ-031 start high during reset or coincident with the release edge SHALL be ignored.

Verification
REQ-032 N=3, mode 00, lut_a=8'hCF, lut_b=8'hCF, start -> busy 8 cycles, done next cycle, equal=1, count=0, first_valid=0.
REQ-033 N=3, mode 00, lut_a=8'hCF, lut_b=8'hCE -> equal=0, count=1, first_mismatch=0, first_valid=1.
REQ-034 N=3, mode 01, lut_a=8'hFF, lut_b=8'h0F -> equal=0, count=4, first_mismatch=4; mode 01, a=8'h0F, b=8'hCF -> equal=1.
REQ-035 N=3, mode 10, lut_a=8'hCF, lut_b=8'h30 -> equal=1; same tables mode 11 -> count=8, first_mismatch=0.
REQ-036 Start accepted, rst_n low while vec=3 -> all outputs 0 immediately, no done; restart after release -> full 8-cycle sweep, correct results.
REQ-037 start pulsed at vec=5 with changed lut_b -> ignored; results match original capture; done exactly once.

Source files
------------

// File: rtl/lut_equiv_checker.sv
// Sweeps every input vector of two captured truth tables and reports
// equality / implication / complement mismatches with count and first index.
module lut_equiv_checker #(
  parameter int N = 3,
  parameter int T = 2**N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [T-1:0] lut_a,
  input  logic [T-1:0] lut_b,
  output logic         busy,
  output logic         done,
  output logic         equal,
  output logic [N:0]   mismatch_count,
  output logic [N-1:0] first_mismatch,
  output logic         first_valid,
  output logic [N-1:0] vec,
  output logic         fa,
  output logic         fb
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DONE
  } state_e;

  localparam logic [N-1:0] LAST = N'(T - 1);

  state_e       state_q, state_d;
  logic         armed_q, armed_d;
  logic [T-1:0] a_q, a_d;
  logic [T-1:0] b_q, b_d;
  logic [1:0]   mode_q, mode_d;
  logic [N-1:0] vec_q, vec_d;
  logic [N:0]   cnt_q, cnt_d;
  logic [N-1:0] first_q, first_d;
  logic         fv_q, fv_d;
  logic         eq_q, eq_d;

  logic         fa_w;
  logic         fb_w;
  logic         miss;

  assign fa_w = a_q[vec_q];
  assign fb_w = b_q[vec_q];

  always_comb begin
    unique case (mode_q)
      2'b01:   miss = fa_w & ~fb_w;
      2'b10:   miss = (fa_w == fb_w);
      default: miss = fa_w ^ fb_w;
    endcase
  end

  // armed_q blocks a start seen on the very edge that releases reset
  always_comb begin
    state_d = state_q;
    armed_d = 1'b1;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    fv_d    = fv_q;
    eq_d    = eq_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && armed_q) begin
          a_d     = lut_a;
          b_d     = lut_b;
          mode_d  = mode;
          vec_d   = '0;
          cnt_d   = '0;
          first_d = '0;
          fv_d    = 1'b0;
          eq_d    = 1'b0;
          state_d = S_SWEEP;
        end
      end
      S_SWEEP: begin
        if (miss) begin
          cnt_d = cnt_q + (N+1)'(1);
          if (!fv_q) begin
            first_d = vec_q;
            fv_d    = 1'b1;
          end
        end
        if (vec_q == LAST) begin
          eq_d    = (cnt_d == '0);
          vec_d   = '0;
          state_d = S_DONE;
        end else begin
          vec_d = vec_q + N'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      armed_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      first_q <= '0;
      fv_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      fv_q    <= fv_d;
      eq_q    <= eq_d;
    end
  end

  assign busy           = (state_q == S_SWEEP);
  assign done           = (state_q == S_DONE);
  assign equal          = eq_q;
  assign mismatch_count = cnt_q;
  assign first_mismatch = first_q;
  assign first_valid    = fv_q;
  assign vec            = busy ? vec_q : '0;
  assign fa             = busy & fa_w;
  assign fb             = busy & fb_w;

endmodule

// File: tb/tb_lut_equiv_checker.sv
// Table-driven bench with an expected-result queue for lut_equiv_checker,
// plus hand sequences for mid-sweep reset and ignored restarts.
module tb_lut_equiv_checker;

  localparam int N = 3;
  localparam int T = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   mode;
  logic [T-1:0] lut_a;
  logic [T-1:0] lut_b;
  logic         busy;
  logic         done;
  logic         equal;
  logic [N:0]   mismatch_count;
  logic [N-1:0] first_mismatch;
  logic         first_valid;
  logic [N-1:0] vec;
  logic         fa;
  logic         fb;

  lut_equiv_checker #(.N(N)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .mode           (mode),
    .lut_a          (lut_a),
    .lut_b          (lut_b),
    .busy           (busy),
    .done           (done),
    .equal          (equal),
    .mismatch_count (mismatch_count),
    .first_mismatch (first_mismatch),
    .first_valid    (first_valid),
    .vec            (vec),
    .fa             (fa),
    .fb             (fb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       eq;
    logic [3:0] cnt;
    logic [2:0] first;
    logic       fv;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[12];
  int   checks;
  int   failures;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] all_outs();
    return {busy, done, equal, mismatch_count, first_mismatch,
            first_valid, vec, fa, fb};
  endfunction

  // chg_at >= 0 pulses start with a different table at that vector
  task automatic run(input vec_t v, input int chg_at, input logic [7:0] alt_b);
    vec_t       e;
    int         busy_n;
    int         idx;
    bit         got;
    bit         bad;
    logic [2:0] ix;
    sb.push_back(v);
    @(negedge clk);
    start = 1'b1;
    mode  = v.mode;
    lut_a = v.a;
    lut_b = v.b;
    @(negedge clk);
    start  = 1'b0;
    busy_n = 0;
    idx    = 0;
    got    = 0;
    bad    = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      start = 1'b0;
      if (busy && done) bad = 1;
      if (busy) begin
        ix = idx[2:0];
        if (vec !== ix || fa !== v.a[ix] || fb !== v.b[ix]) begin
          if (!bad)
            $display("FAIL trace_detail vec=%0d fa=%0b fb=%0b want %0d %0b %0b",
                     vec, fa, fb, ix, v.a[ix], v.b[ix]);
          bad = 1;
        end
        if (idx == chg_at) begin
          start = 1'b1;
          lut_b = alt_b;
          mode  = ~v.mode;
        end
        busy_n++;
        idx++;
      end else if (done) begin
        got = 1;
      end
      if (!got) @(negedge clk);
    end
    start = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=none required=done");
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    chk("trace_ok", {31'd0, bad}, 32'd0);
    chk("busy_cycles", busy_n, T);
    chk("equal", {31'd0, equal}, {31'd0, e.eq});
    chk("count", {28'd0, mismatch_count}, {28'd0, e.cnt});
    chk("first_valid", {31'd0, first_valid}, {31'd0, e.fv});
    if (e.fv)
      chk("first_mismatch", {29'd0, first_mismatch}, {29'd0, e.first});
    @(negedge clk);
    chk("done_once", {30'd0, busy, done}, 32'd0);
    chk("hold", {26'd0, equal, mismatch_count, first_valid},
        {26'd0, e.eq, e.cnt, e.fv});
  endtask

  initial begin
    vec_t v;
    bit   hit;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    mode     = 2'b00;
    lut_a    = '0;
    lut_b    = '0;

    tbl[0]  = '{2'b00, 8'hCF, 8'hCF, 1'b1, 4'd0, 3'd0, 1'b0};
    tbl[1]  = '{2'b00, 8'hCF, 8'hCE, 1'b0, 4'd1, 3'd0, 1'b1};
    tbl[2]  = '{2'b01, 8'hFF, 8'h0F, 1'b0, 4'd4, 3'd4, 1'b1};
    tbl[3]  = '{2'b01, 8'h0F, 8'hCF, 1'b1, 4'd0, 3'd0, 1'b0};
    tbl[4]  = '{2'b10, 8'hCF, 8'h30, 1'b1, 4'd0, 3'd0, 1'b0};
    tbl[5]  = '{2'b11, 8'hCF, 8'h30, 1'b0, 4'd8, 3'd0, 1'b1};
    tbl[6]  = '{2'b00, 8'h00, 8'hFF, 1'b0, 4'd8, 3'd0, 1'b1};
    tbl[7]  = '{2'b00, 8'h80, 8'h00, 1'b0, 4'd1, 3'd7, 1'b1};
    tbl[8]  = '{2'b01, 8'h00, 8'hFF, 1'b1, 4'd0, 3'd0, 1'b0};
    tbl[9]  = '{2'b10, 8'hA5, 8'h5A, 1'b1, 4'd0, 3'd0, 1'b0};
    tbl[10] = '{2'b10, 8'hA5, 8'hA5, 1'b0, 4'd8, 3'd0, 1'b1};
    tbl[11] = '{2'b00, 8'h12, 8'h34, 1'b0, 4'd3, 3'd1, 1'b1};

    repeat (2) @(negedge clk);
    chk("reset_outs", {16'd0, all_outs()}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_outs", {16'd0, all_outs()}, 32'd0);

    for (int i = 0; i < 12; i++) run(tbl[i], -1, 8'h00);

    // restart request mid-sweep with a different table must be ignored
    run(tbl[1], 5, 8'hFF);

    // reset in the middle of a sweep
    @(negedge clk);
    start = 1'b1;
    mode  = 2'b00;
    lut_a = 8'h00;
    lut_b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    hit   = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      if (busy && vec == 3'd3) hit = 1;
      else @(negedge clk);
    end
    chk("reach_vec3", {31'd0, hit}, 32'd1);
    chk("count_pre_rst", {28'd0, mismatch_count}, 32'd3);
    #2;
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    chk("async_rst_outs", {16'd0, all_outs()}, 32'd0);
    hit = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) hit = 1;
    end
    chk("no_done_in_rst", {31'd0, hit}, 32'd0);
    @(posedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_start_ign", {16'd0, all_outs()}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    chk("still_idle", {16'd0, all_outs()}, 32'd0);

    v = tbl[2];
    run(v, -1, 8'h00);
    run(tbl[7], -1, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
